// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to pixel pipelines and the display PHY.
interface vga_timing_if #(
    parameter int unsigned CNT_W = 11
);
    logic             pix_ce;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             line_start;
    logic             frame_start;

    modport master (
        output pix_ce, pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
    );

    modport slave (
        input pix_ce, pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel clock-enable, h/v counters, sync decode
// and a pixel-tick delay line that lines sync/enable up with a pipelined pixel source.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned PIX_DIV    = 2,
    parameter int unsigned SYNC_DELAY = 0,
    parameter int unsigned CNT_W      = 11
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int          DLY     = int'(SYNC_DELAY);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Illegal rasters are rejected at elaboration rather than handled in logic.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIX_DIV < 1 || SYNC_DELAY > 7 ||
        64'(H_TOTAL) > (64'(1) << CNT_W) || 64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_param_check
        $error("vga_timing_gen: illegal timing parameters");
    end

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = sync_t'({~H_POL, ~V_POL, 1'b0});

    logic [DIV_W-1:0] div;
    logic             pix_ce;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
    sync_t            cur_c;
    sync_t            dly [DLY+1];

    // Sync levels already polarity-mapped so every delay stage idles at the inactive level.
    always_comb begin
        cur_c    = SYNC_IDLE;
        cur_c.hs = ((h_count >= HS_BEG) && (h_count < HS_END)) ? H_POL : ~H_POL;
        cur_c.vs = ((v_count >= VS_BEG) && (v_count < VS_END)) ? V_POL : ~V_POL;
        cur_c.de = (h_count < H_ACT) && (v_count < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i <= DLY; i++) begin
                dly[i] <= SYNC_IDLE;
            end
        end else begin
            div         <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            pix_ce      <= (div == DIV_LAST);
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    v_count <= (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
                end else begin
                    h_count <= h_count + CNT_W'(1);
                end
                pixel_x     <= h_count;
                pixel_y     <= v_count;
                line_start  <= (h_count == '0);
                frame_start <= (h_count == '0) && (v_count == '0);
                dly[0]      <= cur_c;
                for (int i = 1; i <= DLY; i++) begin
                    dly[i] <= dly[i-1];
                end
            end
        end
    end

    assign vid.pix_ce      = pix_ce;
    assign vid.pixel_x     = pixel_x;
    assign vid.pixel_y     = pixel_y;
    assign vid.hsync       = dly[DLY].hs;
    assign vid.vsync       = dly[DLY].vs;
    assign vid.video_on    = dly[DLY].de;
    assign vid.line_start  = line_start;
    assign vid.frame_start = frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: five configurations share clk/rst and are checked
// every clk against tick-index arithmetic plus hand-counted pulse totals.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    vga_timing_if #(.CNT_W(11)) if_a ();
    vga_timing_if #(.CNT_W(4))  if_b ();
    vga_timing_if #(.CNT_W(4))  if_c ();
    vga_timing_if #(.CNT_W(4))  if_d ();
    vga_timing_if #(.CNT_W(4))  if_e ();

    vga_timing_gen u_a (.clk(clk), .rst(rst), .vid(if_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(1), .CNT_W(4)
    ) u_b (.clk(clk), .rst(rst), .vid(if_b));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .CNT_W(4)
    ) u_c (.clk(clk), .rst(rst), .vid(if_c));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(1), .SYNC_DELAY(3), .CNT_W(4)
    ) u_d (.clk(clk), .rst(rst), .vid(if_d));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(3), .CNT_W(4)
    ) u_e (.clk(clk), .rst(rst), .vid(if_e));

    typedef struct {
        bit ce;
        int px;
        int py;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int cnt_b_fs;
    int cnt_b_ls;
    int cnt_a_hs_low;
    int cnt_e_ce;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // j = active clk edges since reset release (edge 0 is the first); j < 0 means in reset.
    function automatic exp_t model(input int j, input int p, input int sd,
                                   input int ha, input int hf, input int hw, input int hb,
                                   input int va, input int vf, input int vw, input int vb,
                                   input bit hp, input bit vp);
        exp_t e;
        int ht, vt, n, t, s, x, y;
        ht   = ha + hf + hw + hb;
        vt   = va + vf + vw + vb;
        e.ce = 1'b0; e.px = 0; e.py = 0; e.hs = !hp; e.vs = !vp; e.de = 1'b0;
        e.ls = 1'b0; e.fs = 1'b0;
        if (j < 0) return e;
        e.ce = ((j % p) == (p - 1));
        n    = j / p;
        if (n >= 1) begin
            t    = n - 1;
            x    = t % ht;
            y    = (t / ht) % vt;
            e.px = x;
            e.py = y;
            if ((j % p) == 0) begin
                e.ls = (x == 0);
                e.fs = (x == 0) && (y == 0);
            end
            s = t - sd;
            if (s >= 0) begin
                x    = s % ht;
                y    = (s / ht) % vt;
                e.hs = (x >= ha + hf && x < ha + hf + hw) ? hp : !hp;
                e.vs = (y >= va + vf && y < va + vf + vw) ? vp : !vp;
                e.de = (x < ha) && (y < va);
            end
        end
        return e;
    endfunction

    task automatic check_inst(input string nm, input int j, input exp_t e,
                              input logic ce, input logic [31:0] px, input logic [31:0] py,
                              input logic hs, input logic vs, input logic de,
                              input logic ls, input logic fs);
        check_eq($sformatf("%s.pix_ce j=%0d", nm, j),      32'(ce), 32'(e.ce));
        check_eq($sformatf("%s.pixel_x j=%0d", nm, j),     px,      32'(e.px));
        check_eq($sformatf("%s.pixel_y j=%0d", nm, j),     py,      32'(e.py));
        check_eq($sformatf("%s.hsync j=%0d", nm, j),       32'(hs), 32'(e.hs));
        check_eq($sformatf("%s.vsync j=%0d", nm, j),       32'(vs), 32'(e.vs));
        check_eq($sformatf("%s.video_on j=%0d", nm, j),    32'(de), 32'(e.de));
        check_eq($sformatf("%s.line_start j=%0d", nm, j),  32'(ls), 32'(e.ls));
        check_eq($sformatf("%s.frame_start j=%0d", nm, j), 32'(fs), 32'(e.fs));
    endtask

    task automatic check_all(input int j);
        check_inst("a", j, model(j, 2, 0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0),
                   if_a.pix_ce, 32'(if_a.pixel_x), 32'(if_a.pixel_y), if_a.hsync, if_a.vsync,
                   if_a.video_on, if_a.line_start, if_a.frame_start);
        check_inst("b", j, model(j, 1, 0, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0),
                   if_b.pix_ce, 32'(if_b.pixel_x), 32'(if_b.pixel_y), if_b.hsync, if_b.vsync,
                   if_b.video_on, if_b.line_start, if_b.frame_start);
        check_inst("c", j, model(j, 1, 0, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1),
                   if_c.pix_ce, 32'(if_c.pixel_x), 32'(if_c.pixel_y), if_c.hsync, if_c.vsync,
                   if_c.video_on, if_c.line_start, if_c.frame_start);
        check_inst("d", j, model(j, 1, 3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0),
                   if_d.pix_ce, 32'(if_d.pixel_x), 32'(if_d.pixel_y), if_d.hsync, if_d.vsync,
                   if_d.video_on, if_d.line_start, if_d.frame_start);
        check_inst("e", j, model(j, 3, 0, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0),
                   if_e.pix_ce, 32'(if_e.pixel_x), 32'(if_e.pixel_y), if_e.hsync, if_e.vsync,
                   if_e.video_on, if_e.line_start, if_e.frame_start);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(j);
            if (if_b.frame_start) cnt_b_fs++;
            if (if_b.line_start)  cnt_b_ls++;
            if (!if_a.hsync)      cnt_a_hs_low++;
            if (if_e.pix_ce)      cnt_e_ce++;
        end
    endtask

    initial begin
        cnt_b_fs = 0; cnt_b_ls = 0; cnt_a_hs_low = 0; cnt_e_ce = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all(-1);

        // Cold start: 2481 clks ends with instance d inside its (delayed) vsync pulse.
        rst = 1'b1;
        run(2481);
        check_eq("b.frame_start_count",  32'(cnt_b_fs),     32'd21);
        check_eq("b.line_start_count",   32'(cnt_b_ls),     32'd166);
        check_eq("a.hsync_low_clks",     32'(cnt_a_hs_low), 32'd192);
        check_eq("e.pix_ce_count",       32'(cnt_e_ce),     32'd827);
        check_eq("d.in_vsync_before_rst", 32'(if_d.vsync),  32'd0);

        // One-clk reset mid-vsync: everything idles next clk, then raster restarts cleanly.
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all(-1);
        rst = 1'b1;
        run(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync generator. Produces hsync/vsync, data-enable, pixel coordinates and frame/line strobes for any raster timing and sync polarity.
- Runs on the system clock with an internal pixel clock-enable, not a divided clock, so downstream logic stays single-domain.
- Has a programmable sync/enable delay line that aligns sync with a pipelined pixel source (framebuffer read, font ROM).

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- PIX_DIV, 2, clk cycles per pixel (>=1; 1 = pix_ce tied high after reset)
- SYNC_DELAY, 0, extra pixel ticks applied to hsync/vsync/video_on relative to pixel_x/pixel_y (0..7)
- CNT_W, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- pix_ce  out  1  one-clk pixel strobe, every PIX_DIV clocks
- pixel_x  out  CNT_W  horizontal count of current pixel tick
- pixel_y  out  CNT_W  vertical count of current pixel tick
- hsync  out  1  horizontal sync, polarity H_POL, delayed SYNC_DELAY ticks
- vsync  out  1  vertical sync, polarity V_POL, delayed SYNC_DELAY ticks
- video_on  out  1  active-region enable, delayed SYNC_DELAY ticks
- line_start  out  1  one-clk pulse at the tick where h_count==0
- frame_start  out  1  one-clk pulse at the tick where h_count==0 and v_count==0

Behaviour:
- Reset is clk-synchronous, active-low (rst==0), and overrides everything.
- Reset values:
  - div counter = 0, pix_ce = 0, h_count = v_count = 0, pixel_x = pixel_y = 0
  - hsync = ~H_POL, vsync = ~V_POL, video_on = 0
  - line_start = frame_start = 0
  - every delay-line stage is loaded with the inactive values
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider: counts 0..PIX_DIV-1; pix_ce = 1 for the one clk in which div==PIX_DIV-1. The first pix_ce comes PIX_DIV clks after rst deasserts.
- Counters advance only on clks where pix_ce==1:
  - h_count: 0..H_TOTAL-1, then wraps to 0.
  - v_count increments only when h_count wraps; 0..V_TOTAL-1, then wraps to 0.
- Decode from current counts:
  - hs_act = h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_act = v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - de = (h_count < H_ACTIVE) && (v_count < V_ACTIVE)
- Stage 1 (registered when pix_ce==1):
  - pixel_x, pixel_y take the counts.
  - line_start / frame_start are set high for exactly the pix_ce clk cycle following the tick whose counts matched; low otherwise.
- Outputs hold between ticks, except the two strobes.
- Delay line: an SYNC_DELAY-deep shift register of {hs_act, vs_act, de} following stage 1, shifted only on pix_ce.
  - hsync = hs_d ? H_POL : ~H_POL; vsync likewise with V_POL.
  - SYNC_DELAY=0 means sync and enable align with pixel_x/pixel_y.
- Latency: count value -> pixel_x is 1 pixel tick; count value -> hsync/vsync/video_on is 1+SYNC_DELAY pixel ticks.
- Vsync transitions only on ticks where h_count==0, so it is line-aligned.
- Reset mid-frame: on the next clk all state returns to reset values and the delay line is flushed, so no stale sync pulse emerges. The raster restarts at (0,0) with frame_start on the first tick.
- Parameter legality: all porch/sync values >=1, H_TOTAL <= 2^CNT_W, V_TOTAL <= 2^CNT_W. Violations are caught by an elaboration-time check, not handled in logic.

Test Plan:
- Defaults, PIX_DIV=2 -> pix_ce period 2 clks; hsync period 800 ticks, low for ticks 656..751; vsync low on lines 490..491; frame = 800*525 ticks; video_on high 640 ticks/line on lines 0..479.
- Small raster H=8/2/3/2, V=4/1/2/1, PIX_DIV=1 -> pixel_x sequence 0..14 wrap, pixel_y 0..7 wrap; frame_start once every 120 clks; line_start every 15 clks.
- H_POL=1, V_POL=1 -> hsync high only for h in 10..12; vsync high only for lines 5..6; idle levels 0, including under reset.
- SYNC_DELAY=3, small raster -> video_on rises exactly 3 pixel ticks after pixel_x becomes 0 on line 0; hsync edges shifted by 3 ticks vs the SYNC_DELAY=0 run.
- Assert rst=0 for 1 clk while inside the vsync pulse, SYNC_DELAY=3 -> next clk all outputs inactive/zero; no sync pulse emerges from the delay line; first frame_start after PIX_DIV+1 clks; subsequent timing identical to cold start.
- PIX_DIV=3 -> pix_ce high 1 of every 3 clks; counters and outputs hold steady on non-ce clks; strobes last exactly 1 clk.
